// File: rtl/pipelined_barrel_shifter.sv
// rtl/pipelined_barrel_shifter.sv - pipelined SLL/SRL/SRA/ROR barrel shifter, one log2 level per stage
// Optional outputs out_zero/out_lost are built when SHIFTER_FLAGS_EN is defined.
module pipelined_barrel_shifter #(
  parameter int WIDTH = 32,
  parameter int TAG_W = 4,
  localparam int SHW = $clog2(WIDTH)
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic [SHW-1:0]   in_shamt,
  input  logic [1:0]       in_op,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
`ifdef SHIFTER_FLAGS_EN
  output logic             out_zero,
  output logic             out_lost,
`endif
  output logic [TAG_W-1:0] out_tag
);

  localparam logic [1:0] OP_SLL = 2'b00;
  localparam logic [1:0] OP_SRL = 2'b01;
  localparam logic [1:0] OP_SRA = 2'b10;

  logic             valid_q [SHW];
  logic             valid_d [SHW];
  logic [WIDTH-1:0] data_q  [SHW];
  logic [WIDTH-1:0] data_d  [SHW];
  logic [SHW-1:0]   shamt_q [SHW];
  logic [SHW-1:0]   shamt_d [SHW];
  logic [1:0]       op_q    [SHW];
  logic [1:0]       op_d    [SHW];
  logic [TAG_W-1:0] tag_q   [SHW];
  logic [TAG_W-1:0] tag_d   [SHW];

  logic             s_valid [SHW];
  logic [WIDTH-1:0] s_data  [SHW];
  logic [SHW-1:0]   s_shamt [SHW];
  logic [1:0]       s_op    [SHW];
  logic [TAG_W-1:0] s_tag   [SHW];

  logic stall;
  logic unused_tail;

  assign stall    = valid_q[SHW-1] & ~out_ready;
  assign in_ready = reset_n & ~stall;

  function automatic logic [WIDTH-1:0] shift_level(input logic [WIDTH-1:0] x,
                                                   input logic [1:0] op, input int amt);
    case (op)
      OP_SLL:  return x << amt;
      OP_SRL:  return x >> amt;
      OP_SRA:  return $signed(x) >>> amt;
      default: return (x >> amt) | (x << (WIDTH - amt));
    endcase
  endfunction

  always_comb begin
    s_valid[0] = in_valid & in_ready;
    s_data[0]  = in_data;
    s_shamt[0] = in_shamt;
    s_op[0]    = in_op;
    s_tag[0]   = in_tag;
    for (int k = 1; k < SHW; k++) begin
      s_valid[k] = valid_q[k-1];
      s_data[k]  = data_q[k-1];
      s_shamt[k] = shamt_q[k-1];
      s_op[k]    = op_q[k-1];
      s_tag[k]   = tag_q[k-1];
    end
  end

  // Payload registers load only for real beats, so bubbles never carry X forward.
  always_comb begin
    for (int k = 0; k < SHW; k++) begin
      valid_d[k] = s_valid[k];
      data_d[k]  = data_q[k];
      shamt_d[k] = shamt_q[k];
      op_d[k]    = op_q[k];
      tag_d[k]   = tag_q[k];
      if (s_valid[k]) begin
        data_d[k]  = s_shamt[k][k] ? shift_level(s_data[k], s_op[k], 1 << k) : s_data[k];
        shamt_d[k] = s_shamt[k];
        op_d[k]    = s_op[k];
        tag_d[k]   = s_tag[k];
      end
    end
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      for (int k = 0; k < SHW; k++) begin
        valid_q[k] <= 1'b0;
        data_q[k]  <= '0;
        shamt_q[k] <= '0;
        op_q[k]    <= '0;
        tag_q[k]   <= '0;
      end
    end else if (!stall) begin
      for (int k = 0; k < SHW; k++) begin
        valid_q[k] <= valid_d[k];
        data_q[k]  <= data_d[k];
        shamt_q[k] <= shamt_d[k];
        op_q[k]    <= op_d[k];
        tag_q[k]   <= tag_d[k];
      end
    end
  end

  assign out_valid   = valid_q[SHW-1];
  assign out_data    = data_q[SHW-1];
  assign out_tag     = tag_q[SHW-1];
  assign unused_tail = ^{shamt_q[SHW-1], op_q[SHW-1]};

`ifdef SHIFTER_FLAGS_EN
  logic lost_q [SHW];
  logic lost_d [SHW];
  logic s_lost [SHW];
  logic zero_q;

  // Bits falling off the edge at this level; SRA only counts bits unlike the sign fill.
  function automatic logic lost_level(input logic [WIDTH-1:0] x, input logic [1:0] op,
                                      input int amt);
    logic [WIDTH-1:0] lo_mask;
    logic [WIDTH-1:0] hi_mask;
    lo_mask = ~({WIDTH{1'b1}} << amt);
    hi_mask = ~({WIDTH{1'b1}} >> amt);
    case (op)
      OP_SLL:  return |(x & hi_mask);
      OP_SRL:  return |(x & lo_mask);
      OP_SRA:  return |((x ^ {WIDTH{x[WIDTH-1]}}) & lo_mask);
      default: return 1'b0;
    endcase
  endfunction

  always_comb begin
    s_lost[0] = 1'b0;
    for (int k = 1; k < SHW; k++) s_lost[k] = lost_q[k-1];
    for (int k = 0; k < SHW; k++) begin
      lost_d[k] = lost_q[k];
      if (s_valid[k]) begin
        lost_d[k] = s_lost[k] |
                    (s_shamt[k][k] & lost_level(s_data[k], s_op[k], 1 << k));
      end
    end
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      for (int k = 0; k < SHW; k++) lost_q[k] <= 1'b0;
      zero_q <= 1'b0;
    end else if (!stall) begin
      for (int k = 0; k < SHW; k++) lost_q[k] <= lost_d[k];
      if (s_valid[SHW-1]) zero_q <= (data_d[SHW-1] == '0);
    end
  end

  assign out_zero = zero_q;
  assign out_lost = lost_q[SHW-1];
`endif

endmodule

// File: doc/pipelined_barrel_shifter.md
Name: pipelined_barrel_shifter

Overview:
- Parametrised, fully pipelined barrel shifter for the ALU datapath: SLL, SRL, SRA and ROR in one block.
- One log2 shift level per pipeline stage.
- valid/ready handshake on input and output; whole pipeline stalls under output backpressure.
- Caller tag travels alongside each operand so results can be matched to their issuing operation.

Parameters:
- WIDTH, 32, operand width in bits; must be a power of two, 8 to 64.
- SHW, $clog2(WIDTH), shift-amount width and pipeline depth (derived; not overridden).
- TAG_W, 4, width of the tag carried alongside each operand.

Ports:
- clock  in  1  rising-edge clock.
- reset_n  in  1  synchronous active-low reset.
- in_valid  in  1  input beat present.
- in_ready  out  1  block accepts a beat this cycle.
- in_data  in  WIDTH  operand.
- in_shamt  in  SHW  shift amount, unsigned.
- in_op  in  2  00 SLL, 01 SRL, 10 SRA, 11 ROR.
- in_tag  in  TAG_W  opaque tag, returned unchanged.
- out_valid  out  1  result beat present.
- out_ready  in  1  consumer accepts the result.
- out_data  out  WIDTH  shifted result.
- out_tag  out  TAG_W  tag of this result.

Behaviour:
- Reset: reset_n=0 sampled at a clock edge clears every stage valid bit, data, shamt, op and tag register to 0.
  - out_valid=0, out_data=0, out_tag=0.
  - in_ready=0 while reset_n=0.
  - Reset mid-operation discards all in-flight beats; nothing is emitted for them.
- Pipeline: SHW register stages. Stage k (k=0..SHW-1) applies a shift of 2^k when the carried shamt bit k is 1, else passes the value through.
  - Each stage operates on the previous stage's output, never on the original operand.
  - shamt, op and tag are carried stage to stage.
- Fill rules per stage:
  - SLL and SRL fill with 0.
  - SRA fills with the MSB of that stage's input, which equals the original sign bit.
  - ROR wraps the dropped low bits into the top.
- Latency: exactly SHW cycles from the accepting edge to out_valid=1 when out_ready stays 1 (5 cycles at WIDTH=32).
- Throughput: one beat per cycle.
- Handshake:
  - stall = out_valid & ~out_ready.
  - in_ready = reset_n & ~stall.
  - A beat is accepted on an edge where in_valid & in_ready.
  - While stall=1 every stage holds (global enable); out_data and out_tag stay stable until the edge where out_ready=1.
  - When not stalled, empty stages (valid=0) advance as bubbles.
  - in_valid with in_ready=0: input not consumed; the source must hold it.
- Boundaries:
  - shamt=0 returns in_data unchanged for every op.
  - shamt=WIDTH-1 is the maximum shift: SRA of a negative operand gives all ones; SLL/SRL keep a single bit.
  - Inputs with in_valid=0 have no effect; X on data is ignored.
  - Simultaneous output drain and input accept in the same cycle is legal and keeps a full pipeline at full rate.

Optional Feature:
- Macro: SHIFTER_FLAGS_EN.
- When defined:
  - Adds outputs out_zero (1 bit; 1 when out_data==0) and out_lost (1 bit).
  - out_lost=1 for SLL when any 1 bit was shifted out, and for SRL/SRA when any bit differing from the fill value was shifted out; always 0 for ROR.
  - Flags are carried through the pipeline with the same latency and stall behaviour as out_data; reset value is 0.
- When undefined: the ports do not exist and no flag logic is generated.

Test Plan (WIDTH=32, TAG_W=4):
- Reset then idle: reset_n=0 for 2 cycles, then 1 -> out_valid=0, out_data=0, in_ready=1 on the first cycle after release.
- Single beats, out_ready=1:
  - in_data=0x80000000, op=SRA, shamt=4, tag=3 -> 5 cycles later out_data=0xF8000000, out_tag=3.
  - in_data=0x80000000, op=SRL, shamt=4 -> out_data=0x08000000.
- Rotate and left-shift limits:
  - in_data=0x00000001, op=ROR, shamt=1 -> 0x80000000.
  - in_data=0x00000001, op=SLL, shamt=31 -> 0x80000000.
  - shamt=0, any op, in_data=0x1234ABCD -> 0x1234ABCD.
- Back-to-back streaming: 8 consecutive beats with tags 0..7 and random data/op/shamt -> 8 consecutive out_valid cycles, in order, each matching a reference model, starting at cycle 5.
- Backpressure: stream beats, hold out_ready=0 for 3 cycles mid-stream.
  - in_ready=0 during the stall.
  - out_data and out_tag stable during the stall.
  - No beat lost or duplicated after release.
- Reset mid-stream: assert reset_n=0 with 3 beats in flight -> out_valid=0 next cycle; none of those tags appear after release.
